// File: rtl/f3m_mult_serial_pkg.sv
// f3m_mult_serial_pkg: GF(3^M) field constants, trit codes and trit helpers shared by the GF(3^M) blocks.
// The illegal-trit helper exists only when F3M_MULT_CHECK_EN is defined.
package f3m_mult_serial_pkg;

    localparam int M     = 97;
    localparam int WIDTH = 2*M-1;
    localparam logic [2*M+1:0] PX = 196'h4000000000000000000000000000000000000000001000002;

    localparam logic [1:0] TRIT0 = 2'b00;
    localparam logic [1:0] TRIT1 = 2'b01;
    localparam logic [1:0] TRIT2 = 2'b10;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [1:0] trit_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // k*X per trit: 2*X is X with the 01/10 codes swapped
    function automatic logic [WIDTH:0] trit_scale(input logic [1:0] k, input logic [WIDTH:0] x);
        logic [WIDTH:0] r;
        for (int i = 0; i < M; i++)
            r[2*i +: 2] = (k == TRIT1) ? x[2*i +: 2] : (k == TRIT2) ? {x[2*i], x[2*i+1]} : TRIT0;
        return r;
    endfunction

`ifdef F3M_MULT_CHECK_EN
    function automatic logic has_illegal(input logic [WIDTH:0] x);
        logic r;
        r = 1'b0;
        for (int i = 0; i < M; i++)
            r = r | (&x[2*i +: 2]);
        return r;
    endfunction
`endif

endpackage

// File: rtl/f3m_add.sv
// f3m_add: combinational GF(3^M) adder, trit-wise addition mod 3.
module f3m_add
    import f3m_mult_serial_pkg::*;
(
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_b,
    output logic [WIDTH:0] o_c
);

    for (genvar g = 0; g < M; g++) begin : g_trit
        assign o_c[2*g +: 2] = trit_add(i_a[2*g +: 2], i_b[2*g +: 2]);
    end

endmodule

// File: rtl/f3m_mul_x.sv
// f3m_mul_x: combinational multiply by x modulo P(x); reusable by the cubing and inversion stages.
module f3m_mul_x
    import f3m_mult_serial_pkg::*;
(
    input  logic [WIDTH:0] i_a,
    output logic [WIDTH:0] o_c
);

    logic [1:0]     w_t;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_red;

    assign w_t   = i_a[WIDTH -: 2];
    assign w_shl = {i_a[WIDTH-2:0], TRIT0};
    // x^M = -P_low, so the overflow trit folds back as (-t)*P_low
    assign w_red = trit_scale({w_t[0], w_t[1]}, PX[WIDTH:0]);

    f3m_add u_add (
        .i_a (w_shl),
        .i_b (w_red),
        .o_c (o_c)
    );

endmodule

// File: rtl/f3m_mult_serial.sv
// f3m_mult_serial: trit-serial GF(3^M) multiplier, C = A*B mod P(x), one trit of B per clock MSB-first.
// Define F3M_MULT_CHECK_EN to flag operands containing the illegal 11 trit code on o_err.
module f3m_mult_serial
    import f3m_mult_serial_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_b,
    output logic           o_busy,
    output logic           o_done,
    output logic [WIDTH:0] o_c,
    output logic           o_err
);

    localparam int CW = $clog2(M);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WIDTH:0]  r_ar;
    logic [WIDTH:0]  r_br;
    logic [WIDTH:0]  r_acc;
    logic [WIDTH:0]  r_c;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            w_accept;
    logic            w_last;
    logic [1:0]      w_bt;
    logic [WIDTH:0]  w_accx;
    logic [WIDTH:0]  w_pp;
    logic [WIDTH:0]  w_sum;

    assign w_bt = r_br[{r_cnt, 1'b0} +: 2];
    assign w_pp = trit_scale(w_bt, r_ar);

    f3m_mul_x u_mul_x (
        .i_a (r_acc),
        .o_c (w_accx)
    );

    f3m_add u_acc_add (
        .i_a (w_accx),
        .i_b (w_pp),
        .o_c (w_sum)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_accept    = (r_state == IDLE) && i_start;
        w_last      = (r_state == RUN) && (r_cnt == '0);
        w_state_nxt = w_accept ? RUN : w_last ? IDLE : r_state;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ar   <= '0;
            r_br   <= '0;
            r_acc  <= '0;
            r_c    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_ar   <= i_a;
                r_br   <= i_b;
                r_acc  <= '0;
                r_cnt  <= CW'(M-1);
                r_busy <= 1'b1;
            end else if (r_state == RUN) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt - 1'b1;
                if (w_last) begin
                    r_c    <= w_sum;
                    r_busy <= 1'b0;
                end
            end
        end
    end

`ifdef F3M_MULT_CHECK_EN
    logic r_err;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_err <= 1'b0;
        else if (w_accept)
            r_err <= has_illegal(i_a) | has_illegal(i_b);
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_c    = r_c;

endmodule

// File: tb/tb_f3m_mult_serial.sv
// tb_f3m_mult_serial: randomized check of f3m_mult_serial against a schoolbook multiply-then-reduce model.
// Illegal-trit err checks are exercised when F3M_MULT_CHECK_EN is defined.
module tb_f3m_mult_serial;
    import f3m_mult_serial_pkg::*;

    localparam int W = 2*M;

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_start = 1'b0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_c;
    logic         o_err;

    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] q_c[$];
    int           q_t[$];
    bit           q_v[$];
    bit           exp_err = 1'b0;

    f3m_mult_serial dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_c     (o_c),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // full polynomial product, then fold every x^k (k >= M) using x^M = -P_low
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int p[2*M-1];
        int t;
        logic [W-1:0] r;
        foreach (p[k]) p[k] = 0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                p[i+j] += int'(a[2*i +: 2]) * int'(b[2*j +: 2]);
        for (int k = 2*M-2; k >= M; k--) begin
            t = p[k] % 3;
            p[k] = 0;
            for (int i = 0; i < M; i++)
                p[k-M+i] += ((3 - int'(PX[2*i +: 2])) % 3) * t;
        end
        r = '0;
        for (int k = 0; k < M; k++) r[2*k +: 2] = 2'(p[k] % 3);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_el();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
        return r;
    endfunction

    function automatic bit any11(input logic [W-1:0] x);
        bit r;
        r = 1'b0;
        for (int i = 0; i < M; i++) r = r | (x[2*i +: 2] == 2'b11);
        return r;
    endfunction

    bit           m_eb;
    int           m_t;
    logic [W-1:0] m_c;
    bit           m_v;

    always @(negedge clk) begin
        if (!i_reset) begin
            m_eb = 1'b0;
            if (q_t.size() > 0) m_eb = (cyc >= q_t[0] - M) && (cyc < q_t[0]);
            chk("busy", {193'b0, o_busy}, {193'b0, m_eb});
            chk("err", {193'b0, o_err}, {193'b0, exp_err});
            if (o_done) begin
                if (q_t.size() == 0) begin
                    chk("spurious_done", {193'b0, o_done}, '0);
                end else begin
                    m_t = q_t.pop_front();
                    m_c = q_c.pop_front();
                    m_v = q_v.pop_front();
                    chk("done_time", W'(cyc), W'(m_t));
                    if (m_v) chk("product", o_c, m_c);
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit v);
        i_a = a;
        i_b = b;
        i_start = 1'b1;
        q_c.push_back(model(a, b));
        q_t.push_back(cyc + 1 + M);
        q_v.push_back(v);
        @(posedge clk);
        #1;
`ifdef F3M_MULT_CHECK_EN
        exp_err = any11(a) | any11(b);
`endif
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!o_done && k < M + 5) begin
            @(negedge clk);
            k++;
        end
        if (!o_done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done within %0d cycles want done", M + 5);
        end
    endtask

    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input bit v);
        issue(a, b, v);
        wait_done();
    endtask

    logic [W-1:0] x96;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] first;

    initial begin
        x96 = '0;
        x96[192] = 1'b1;
        chk("model_1x1", model(W'(1), W'(1)), W'(1));
        chk("model_2x2", model(W'(2), W'(2)), W'(1));
        chk("model_reduce", model(W'(4), x96), W'(32'h2000001));

        repeat (3) @(negedge clk);
        chk("rst_busy", {193'b0, o_busy}, '0);
        chk("rst_done", {193'b0, o_done}, '0);
        chk("rst_c", o_c, '0);
        chk("rst_err", {193'b0, o_err}, '0);
        i_reset = 1'b0;
        @(negedge clk);

        go(W'(1), W'(1), 1'b1);
        chk("t1_c", o_c, W'(1));
        go(W'(2), W'(2), 1'b1);
        chk("t2_c", o_c, W'(1));
        go(W'(4), x96, 1'b1);
        chk("t3_c", o_c, W'(32'h2000001));
        repeat (3) @(negedge clk);
        chk("t3_hold", o_c, W'(32'h2000001));

        // consecutive go calls restart on the done cycle itself
        for (int n = 0; n < 150; n++) go(rnd_el(), rnd_el(), 1'b1);

        ra = rnd_el();
        rb = rnd_el();
        first = model(ra, rb);
        issue(ra, rb, 1'b1);
        repeat (40) @(negedge clk);
        i_a = rnd_el();
        i_b = rnd_el();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done();
        chk("midrun_ignored", o_c, first);

`ifdef F3M_MULT_CHECK_EN
        ra = W'(1);
        ra[11:10] = 2'b11;
        go(ra, W'(1), 1'b0);
        chk("err_set", {193'b0, o_err}, W'(1));
        go(W'(1), W'(2), 1'b1);
        chk("err_clear", {193'b0, o_err}, '0);
`endif

        issue(rnd_el(), rnd_el(), 1'b1);
        repeat (49) @(negedge clk);
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        q_c.delete();
        q_t.delete();
        q_v.delete();
        exp_err = 1'b0;
        @(negedge clk);
        chk("abort_busy", {193'b0, o_busy}, '0);
        chk("abort_c", o_c, '0);
        i_reset = 1'b0;
        repeat (M + 10) @(negedge clk);
        chk("abort_c_after", o_c, '0);

        go(W'(2), W'(1), 1'b1);
        chk("post_abort_c", o_c, W'(2));

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
